// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller port between the LCD reader (client 0) and the compute engine (client 1)
// Ports:
//   clk, rst_n                                  SDRAM-domain clock, async active-low reset
//   c0_req / c0_grant                           client 0 request / ownership
//   c0_command, c0_address, c0_data_write       client 0 bus
//   c0_data_read_valid, c0_data_write_done      beat strobes steered to client 0
//   c1_requested / c1_yield                     yield request to client 1 / client 1 release
//   c1_command, c1_address, c1_data_write       client 1 bus
//   c1_data_read_valid, c1_data_write_done      beat strobes steered to client 1
//   command, data_address, data_write           muxed bus to the SDRAM controller
//   data_read_valid, data_write_done            beat strobes from the SDRAM controller
//   yield_timeout                               sticky: client 1 did not yield in time
// Build option: SDRAM_ARB_FAIR_EN forces a release after MAX_C0_BURSTS bursts and
// then holds client 1 for C1_MIN_CYCLES cycles (S_HOLD).
module sdram_arbiter #(
  parameter int BURST_LEN     = 8,
  parameter int MAX_C0_BURSTS = 4,
  parameter int C1_MIN_CYCLES = 16,
  parameter int YIELD_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c0_req,
  output logic        c0_grant,
  input  logic [1:0]  c0_command,
  input  logic [21:0] c0_address,
  input  logic [31:0] c0_data_write,
  output logic        c0_data_read_valid,
  output logic        c0_data_write_done,
  output logic        c1_requested,
  input  logic        c1_yield,
  input  logic [1:0]  c1_command,
  input  logic [21:0] c1_address,
  input  logic [31:0] c1_data_write,
  output logic        c1_data_read_valid,
  output logic        c1_data_write_done,
  output logic [1:0]  command,
  output logic [21:0] data_address,
  output logic [31:0] data_write,
  input  logic        data_read_valid,
  input  logic        data_write_done,
  output logic        yield_timeout
);
  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam int BW   = $clog2(BURST_LEN);
  localparam int CM1  = YIELD_TIMEOUT > C1_MIN_CYCLES ? YIELD_TIMEOUT : C1_MIN_CYCLES;
  localparam int CMAX = CM1 > MAX_C0_BURSTS ? CM1 : MAX_C0_BURSTS;
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic [1:0] {S_C1, S_REQ, S_C0, S_HOLD} state_t;
  state_t state, nxt;
  logic [BW-1:0] beat;
  // shared counter: yield wait in S_REQ, burst count in S_C0, hold window in S_HOLD
  logic [CW-1:0] cnt;
  // a client-0 command is outstanding; stops the idle release from cutting a burst
  logic pending;
  logic own0, strobe, last, idle_rel, full;
  assign own0     = state == S_C0;
  assign strobe   = own0 & (data_read_valid | data_write_done);
  assign last     = strobe && beat == BW'(BURST_LEN - 1);
  assign idle_rel = !pending && beat == '0 && c0_command == CMD_IDLE && !c0_req;
`ifdef SDRAM_ARB_FAIR_EN
  assign full = last && cnt == CW'(MAX_C0_BURSTS - 1);
`else
  assign full = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= S_C1;
      beat          <= '0;
      cnt           <= '0;
      pending       <= 1'b0;
      yield_timeout <= 1'b0;
    end else begin
      state   <= nxt;
      beat    <= !own0 ? '0 : last ? '0 : strobe ? beat + 1'b1 : beat;
      pending <= own0 && (c0_command != CMD_IDLE || (pending && !last));
      cnt     <= state != nxt ? '0 : (cnt != CW'(CMAX) && (!own0 || last)) ? cnt + 1'b1 : cnt;
      if (state == S_REQ && cnt == CW'(YIELD_TIMEOUT - 1)) yield_timeout <= 1'b1;
    end
  always_comb begin
    nxt = state;
    case (state)
      S_C1:    nxt = c0_req ? S_REQ : S_C1;
      S_REQ:   nxt = c1_yield ? S_C0 : S_REQ;
      S_C0:    nxt = full ? S_HOLD : ((last && !c0_req) || idle_rel) ? S_C1 : S_C0;
      S_HOLD:  nxt = cnt == CW'(C1_MIN_CYCLES - 1) ? S_C1 : S_HOLD;
      default: nxt = S_C1;
    endcase
  end
  always_comb begin
    c0_grant           = own0;
    c1_requested       = state == S_REQ;
    command            = own0 ? c0_command : c1_command;
    data_address       = own0 ? c0_address : c1_address;
    data_write         = own0 ? c0_data_write : c1_data_write;
    c0_data_read_valid = own0 & data_read_valid;
    c0_data_write_done = own0 & data_write_done;
    c1_data_read_valid = !own0 & data_read_valid;
    c1_data_write_done = !own0 & data_write_done;
  end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares the single SDRAM controller port between two masters: the LCD scanout reader (client 0, latency-critical, request/grant) and the fractal compute engine (client 1, default owner, request/yield handshake). Sits between both clients and the SDRAM controller, multiplexing command, address and write data, and steering beat strobes back to the current owner. Guarantees burst-atomic handover: ownership changes only between bursts.

## Interface
- BURST_LEN, 8: beats per client-0 burst; must equal the SDRAM controller burst length.
- MAX_C0_BURSTS, 4: consecutive client-0 bursts before a forced release (fairness build only).
- C1_MIN_CYCLES, 16: guaranteed client-1 hold window after a forced release (fairness build only).
- YIELD_TIMEOUT, 1023: cycles in S_REQ before the timeout flag sets.
- i_Clk  in  1  SDRAM-domain clock.
- i_Rst_n  in  1  reset, asynchronous, active-low.
- i_C0_Req  in  1  client 0 wants the bus.
- o_C0_Grant  out  1  client 0 owns the bus.
- i_C0_Command / i_C0_Address / i_C0_Data_Write  in  2/22/32  client 0 bus.
- o_C0_Data_Read_Valid / o_C0_Data_Write_Done  out  1/1  steered beat strobes.
- o_C1_Requested  out  1  asks client 1 to yield.
- i_C1_Yield  in  1  client 1 is idle and releases the bus.
- i_C1_Command / i_C1_Address / i_C1_Data_Write  in  2/22/32  client 1 bus.
- o_C1_Data_Read_Valid / o_C1_Data_Write_Done  out  1/1  steered beat strobes.
- o_Command / o_Data_Address / o_Data_Write  out  2/22/32  to SDRAM controller.
- i_Data_Read_Valid / i_Data_Write_Done  in  1/1  from SDRAM controller.
- o_Yield_Timeout  out  1  sticky: client 1 failed to yield in time.

## Operation
- States: S_C1 (client 1 owns), S_REQ (yield requested, client 1 still owns), S_C0 (client 0 owns), S_HOLD (client 1 owns, client 0 requests ignored; fairness build only).
- Owner = C0 in S_C0, else C1. o_Command/o_Data_Address/o_Data_Write combinationally muxed from the owner; beat strobes ANDed with owner select; non-owner strobes are 0.
- S_C1: i_C0_Req=1 -> S_REQ.
- S_REQ: o_C1_Requested=1; i_C1_Yield=1 -> S_C0. Wait counter increments each cycle; reaching YIELD_TIMEOUT sets o_Yield_Timeout (cleared only by reset); state remains S_REQ.
- S_C0: o_C0_Grant=1. Beat counter (clog2(BURST_LEN) bits) increments on owner-steered strobe; wraps to 0 on beat BURST_LEN-1, incrementing the burst counter.
- Release from S_C0 when (a) last beat of a burst occurs and i_C0_Req=0, or (b) beat counter=0, i_C0_Command=CMD_IDLE, i_C0_Req=0. Next state S_C1.
- Client 0 drops i_C0_Req only after its final burst's command is issued; arbiter never truncates a burst.

## Timing
- Reset (async, immediate): state S_C1, all counters 0, o_C0_Grant=0, o_C1_Requested=0, o_Yield_Timeout=0, all C0 strobes 0; bus outputs mirror client 1 inputs.
- i_C0_Req rises cycle n (in S_C1) -> o_C1_Requested=1 at n+1; yield sampled n+1 -> o_C0_Grant=1 at n+2. Minimum acquisition latency 2 cycles, even if i_C1_Yield already high.
- Final beat at cycle m -> o_C0_Grant=0 and bus reverts to client 1 at m+1.
- o_C1_Requested is 0 in every state except S_REQ.
- Reset mid-burst: grant drops asynchronously; clients are reset by the same net.

## Configuration
- SDRAM_ARB_FAIR_EN defined: release condition (c) added — last beat of burst MAX_C0_BURSTS -> S_HOLD regardless of i_C0_Req; S_HOLD counts C1_MIN_CYCLES cycles then -> S_C1 (re-arbitration resumes). Client 0 must tolerate grant loss at burst boundaries.
- Undefined: no burst counter, no S_HOLD; client 0 holds the bus while i_C0_Req=1.

## Test plan
- Idle client 1, pulse i_C0_Req at cycle 10 with i_C1_Yield=1 -> o_C1_Requested at 11, o_C0_Grant at 12, o_Command follows i_C0_Command from 12.
- Client 0 read burst of 8 beats, i_C0_Req dropped after issue -> o_C0_Data_Read_Valid pulses 8 times, o_C1_Data_Read_Valid 0 throughout, grant low cycle after beat 8.
- i_C1_Yield held 0 for 1023 cycles in S_REQ -> o_Yield_Timeout=1, stays 1 after later yield; clears only on i_Rst_n=0.
- FAIR_EN, i_C0_Req held high -> exactly 32 beats, grant low for 16+ cycles (o_C1_Requested=0), then re-request cycle.
- Assert i_Rst_n=0 at beat 3 of a client-0 burst -> o_C0_Grant=0 same cycle, bus mirrors client 1.
- Non-FAIR build, i_C0_Req held high for 40 bursts -> grant never drops.
